sig_frame_packer: RTL and testbench
===================================

# sig_frame_packer

Byte-stream to frame packer that sits directly upstream of `top` and drives its `sig_a`/`sig_b`/`sig_c`/`sig_d` inputs. It collects up to three bytes from a valid/ready byte stream into one frame. A frame ends at three bytes, at an `in_last` byte, or on an idle timeout. It presents the frame with a byte count and running prefix sums, holding it under a valid/ready handshake.

## Interface
- `PAD_BYTE`, default 8'h00: fill value for unused byte lanes of short frames.
- `TIMEOUT`, default 16: idle cycles after which a partial frame is flushed; 0 disables the timeout. Counter is 8 bits, legal range 0..255.

- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  byte available.
- `in_ready`  out  1  packer accepts a byte this cycle.
- `in_data`  in  8  byte value.
- `in_last`  in  1  byte ends the frame.
- `sig_a`  out  1  frame valid; registered.
- `sig_a_rdy`  in  1  downstream accepts the frame.
- `sig_b`  out  2  valid byte count: 2'd1..2'd3; 2'd0 only while `sig_a`=0.
- `sig_c`  out  [0:2][7:0]  frame bytes; `sig_c[0]` is the first byte received.
- `sig_d`  out  [7:0] x [3] (unpacked)  prefix sums: `sig_d[i]` = (`sig_c[0]` + … + `sig_c[i]`) mod 256.

## Operation
- Collector FSM:
  - EMPTY: count 0.
  - PART: 1–2 bytes held.
  - HOLD: frame complete, output register busy.
- `in_ready` = (state != HOLD).
- A byte is accepted when `in_valid` && `in_ready`. It is written to lane `count`, then count increments.
- Completion occurs on the accepting edge when the new count is 3 or `in_last`=1. It also occurs when the PART idle counter reaches `TIMEOUT`.
- Output register is free when `!sig_a || sig_a_rdy`.
- On completion:
  - Output free: the frame transfers to the output register on that edge and the collector goes to EMPTY.
  - Output not free: the collector goes to HOLD.
  - HOLD transfers on the first edge where the output is free, then goes to EMPTY.
- On transfer:
  - Lanes ≥ count load `PAD_BYTE`.
  - `sig_b` = count.
  - `sig_d` is computed from the padded `sig_c`, so pad bytes are included in the sums. Each add is 8-bit and carries are discarded.
- `sig_a` clears on a handshake (`sig_a` && `sig_a_rdy`) unless a transfer occurs on the same edge. In that case `sig_a` stays 1 with the new frame (back-to-back frames).
- Idle counter:
  - Resets to 0 on every accepted byte and whenever the state is not PART.
  - Otherwise increments in PART.
  - Timeout fires when the counter == `TIMEOUT` and `TIMEOUT` != 0.
- If the timeout fires and a byte is accepted in the same cycle, the byte wins: it is accepted and the counter resets.
- `in_valid`=1 with `in_last`=1 in EMPTY gives a 1-byte frame.
- `in_last` is ignored when `in_valid`=0.
- `sig_c`, `sig_b` and `sig_d` remain stable while `sig_a`=1 and `sig_a_rdy`=0.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - `sig_a`=0, `sig_b`=0, `sig_c`=0, `sig_d`=0.
  - State EMPTY, count 0, idle counter 0.
  - `in_ready`=1 the cycle after reset deasserts.
- Reset mid-frame or in HOLD discards all held bytes. No partial frame is emitted.
- Latency: completing byte accepted at edge N → `sig_a`=1 after edge N when the output is free.
- Throughput: one 3-byte frame per 3 cycles with `sig_a_rdy` held at 1; no bubbles.
- Timeout flush: last byte accepted at edge N → frame transfers at edge N+`TIMEOUT`+1 when the output is free.
- `in_ready` is combinational from the state only; it has no path from `in_valid` or `sig_a_rdy`.

## Configuration
- `SIG_FRAME_PACKER_SUM_EN` defined: `sig_d` carries the prefix sums as specified.
- Not defined: the sum adders are not compiled; `sig_d` is tied to 0 in every entry, in every cycle.
- All other behaviour is identical in both builds.

## Test plan
- Full frame, no backpressure:
  - Stimulus: bytes 8'h10, 8'h20, 8'hF0 on consecutive cycles, `sig_a_rdy`=1.
  - Response: `sig_a`=1 one cycle after the third byte, `sig_b`=3, `sig_c`={10,20,F0}, `sig_d`={10,30,20} (wrap).
- Short frame:
  - Stimulus: 8'h05 then 8'h07 with `in_last`=1, `PAD_BYTE`=8'hAA.
  - Response: `sig_b`=2, `sig_c`={05,07,AA}, `sig_d`={05,0C,B6}.
- Backpressure:
  - Stimulus: two 3-byte frames, `sig_a_rdy`=0 for 6 cycles.
  - Response: `in_ready`=0 after the second frame completes, first frame stable. Raising `sig_a_rdy` gives frame 2 on the next edge with `sig_a` held 1, then `in_ready`=1.
- Timeout:
  - Stimulus: `TIMEOUT`=4, single byte 8'h33, then idle.
  - Response: frame emitted at edge N+5, `sig_b`=1, `sig_c`={33,00,00}. Repeat with a byte arriving on the timeout cycle: that byte is accepted and no flush occurs.
- Reset mid-operation:
  - Stimulus: 2 bytes accepted, then `rst_n`=0 for one edge.
  - Response: all outputs 0, no frame emitted. The next 3 bytes form a clean frame.
- Macro off:
  - Stimulus: rerun the full-frame test without `SIG_FRAME_PACKER_SUM_EN`.
  - Response: identical `sig_a`/`sig_b`/`sig_c`; `sig_d`=0 throughout.

Source files
------------

// File: rtl/sig_frame_packer_if.sv
// Byte-stream in / frame out bundle for sig_frame_packer.
// master = the environment driving bytes and accepting frames, slave = the packer.
interface sig_frame_packer_if;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_data;
  logic            in_last;
  logic            sig_a;
  logic            sig_a_rdy;
  logic [1:0]      sig_b;
  logic [0:2][7:0] sig_c;
  logic [7:0]      sig_d [3];

  modport master (
    output in_valid, in_data, in_last, sig_a_rdy,
    input  in_ready, sig_a, sig_b, sig_c, sig_d
  );

  modport slave (
    input  in_valid, in_data, in_last, sig_a_rdy,
    output in_ready, sig_a, sig_b, sig_c, sig_d
  );
endinterface

// File: rtl/sig_frame_packer.sv
// Packs up to three stream bytes into a frame (3 bytes, in_last, or idle timeout).
// Define SIG_FRAME_PACKER_SUM_EN to build the prefix-sum adders; otherwise sig_d is 0.
module sig_frame_packer #(
  parameter logic [7:0]  PAD_BYTE = 8'h00,
  parameter int unsigned TIMEOUT  = 16
) (
  input logic               clk,
  input logic               rst_n,
  sig_frame_packer_if.slave bus
);
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [1:0] {EMPTY, PART, HOLD} state_t;

  state_t          state, state_d;
  logic [1:0]      count, count_d, cnt_n;
  logic [7:0]      idle, idle_d;
  logic [0:2][7:0] lanes, lanes_n, padded;
  logic [7:0]      sum_d [3];
  logic            acc, out_free, tmo, complete, xfer;

  assign bus.in_ready = (state != HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_d;
  end

  always_comb begin
    acc      = bus.in_valid && (state != HOLD);
    out_free = !bus.sig_a || bus.sig_a_rdy;
    lanes_n  = lanes;
    cnt_n    = count;
    if (acc) begin
      lanes_n[count] = bus.in_data;
      cnt_n          = count + 2'd1;
    end
    // an accepted byte always beats a timeout landing on the same cycle
    tmo      = (state == PART) && !acc && (TMO != 8'd0) && (idle == TMO);
    complete = (acc && ((cnt_n == 2'd3) || bus.in_last)) || tmo;
    xfer     = 1'b0;
    state_d  = state;
    case (state)
      EMPTY, PART: begin
        if (complete) begin
          xfer    = out_free;
          state_d = out_free ? EMPTY : HOLD;
        end else if (acc) begin
          state_d = PART;
        end
      end
      HOLD: begin
        if (out_free) begin
          xfer    = 1'b1;
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    count_d = (state_d == EMPTY) ? 2'd0 : cnt_n;
    idle_d  = ((state == PART) && !acc) ? idle + 8'd1 : 8'd0;
    for (int i = 0; i < 3; i++)
      padded[i] = (2'(i) < cnt_n) ? lanes_n[i] : PAD_BYTE;
`ifdef SIG_FRAME_PACKER_SUM_EN
    sum_d[0] = padded[0];
    sum_d[1] = padded[0] + padded[1];
    sum_d[2] = padded[0] + padded[1] + padded[2];
`else
    for (int i = 0; i < 3; i++) sum_d[i] = 8'd0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= 2'd0;
      idle      <= 8'd0;
      lanes     <= '0;
      bus.sig_a <= 1'b0;
      bus.sig_b <= 2'd0;
      bus.sig_c <= '0;
      for (int i = 0; i < 3; i++) bus.sig_d[i] <= 8'd0;
    end else begin
      count <= count_d;
      idle  <= idle_d;
      lanes <= lanes_n;
      if (xfer) begin
        bus.sig_a <= 1'b1;
        bus.sig_b <= cnt_n;
        bus.sig_c <= padded;
        for (int i = 0; i < 3; i++) bus.sig_d[i] <= sum_d[i];
      end else if (bus.sig_a && bus.sig_a_rdy) begin
        bus.sig_a <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sig_frame_packer.sv
// Directed bench for sig_frame_packer (PAD_BYTE=AA, TIMEOUT=4); sig_d expectations follow SIG_FRAME_PACKER_SUM_EN.
module tb_sig_frame_packer;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  sig_frame_packer_if bus ();

  sig_frame_packer #(.PAD_BYTE(8'hAA), .TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] dexp(input logic [7:0] v);
`ifdef SIG_FRAME_PACKER_SUM_EN
    return v;
`else
    return 8'h00;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input logic [1:0] b,
                           input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    chk({tag, ".a"},  32'(bus.sig_a), 32'd1);
    chk({tag, ".b"},  32'(bus.sig_b), 32'(b));
    chk({tag, ".c0"}, 32'(bus.sig_c[0]), 32'(c0));
    chk({tag, ".c1"}, 32'(bus.sig_c[1]), 32'(c1));
    chk({tag, ".c2"}, 32'(bus.sig_c[2]), 32'(c2));
    chk({tag, ".d0"}, 32'(bus.sig_d[0]), 32'(dexp(d0)));
    chk({tag, ".d1"}, 32'(bus.sig_d[1]), 32'(dexp(d1)));
    chk({tag, ".d2"}, 32'(bus.sig_d[2]), 32'(dexp(d2)));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".a"}, 32'(bus.sig_a), 32'd0);
    chk({tag, ".b"}, 32'(bus.sig_b), 32'd0);
    chk({tag, ".c"}, 32'(bus.sig_c), 32'd0);
    chk({tag, ".d"}, {8'd0, bus.sig_d[0], bus.sig_d[1], bus.sig_d[2]}, 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.sig_a_rdy = 1'b1;
    step();
    step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);

    // full frame, d2 wraps: 10+20+F0 = 0x120
    bus.in_valid = 1'b1; bus.in_data = 8'h10; step();
    chk("ff_lat", 32'(bus.sig_a), 32'd0);
    bus.in_data = 8'h20; step();
    drive(8'hF0, 1'b0);
    chk_frame("full", 2'd3, 8'h10, 8'h20, 8'hF0, 8'h10, 8'h30, 8'h20);
    step();
    chk("full_clr", 32'(bus.sig_a), 32'd0);

    // two frames back to back, no bubbles
    bus.in_valid = 1'b1;
    bus.in_data = 8'h01; step();
    bus.in_data = 8'h02; step();
    bus.in_data = 8'h03; step();
    chk_frame("b2b1", 2'd3, 8'h01, 8'h02, 8'h03, 8'h01, 8'h03, 8'h06);
    chk("b2b_rdy1", 32'(bus.in_ready), 32'd1);
    bus.in_data = 8'h04; step();
    chk("b2b_gap", 32'(bus.sig_a), 32'd0);
    bus.in_data = 8'h05; step();
    drive(8'h06, 1'b0);
    chk_frame("b2b2", 2'd3, 8'h04, 8'h05, 8'h06, 8'h04, 8'h09, 8'h0F);
    step();

    // short frame padded with AA
    bus.in_valid = 1'b1; bus.in_data = 8'h05; step();
    drive(8'h07, 1'b1);
    chk_frame("short", 2'd2, 8'h05, 8'h07, 8'hAA, 8'h05, 8'h0C, 8'hB6);
    step();

    // backpressure: second frame lands in HOLD
    bus.sig_a_rdy = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data = 8'hA1; step();
    bus.in_data = 8'hA2; step();
    bus.in_data = 8'hA3; step();
    bus.in_data = 8'hB1; step();
    bus.in_data = 8'hB2; step();
    drive(8'hB3, 1'b0);
    chk("bp_hold_rdy", 32'(bus.in_ready), 32'd0);
    chk_frame("bp1", 2'd3, 8'hA1, 8'hA2, 8'hA3, 8'hA1, 8'h43, 8'hE6);
    step();
    chk_frame("bp1_stable", 2'd3, 8'hA1, 8'hA2, 8'hA3, 8'hA1, 8'h43, 8'hE6);
    bus.sig_a_rdy = 1'b1;
    step();
    chk_frame("bp2", 2'd3, 8'hB1, 8'hB2, 8'hB3, 8'hB1, 8'h63, 8'h16);
    chk("bp_rdy_back", 32'(bus.in_ready), 32'd1);
    step();
    chk("bp_clr", 32'(bus.sig_a), 32'd0);

    // timeout: byte at edge N, flush at N+5
    drive(8'h33, 1'b0);
    for (int i = 1; i <= 4; i++) step();
    chk("tmo_early", 32'(bus.sig_a), 32'd0);
    step();
    chk_frame("tmo", 2'd1, 8'h33, 8'hAA, 8'hAA, 8'h33, 8'hDD, 8'h87);
    step();
    chk("tmo_clr", 32'(bus.sig_a), 32'd0);

    // byte on the timeout cycle wins
    drive(8'h33, 1'b0);
    for (int i = 1; i <= 4; i++) step();
    drive(8'h44, 1'b0);
    chk("race_noflush", 32'(bus.sig_a), 32'd0);
    step();
    chk("race_noflush2", 32'(bus.sig_a), 32'd0);
    drive(8'h55, 1'b1);
    chk_frame("race", 2'd3, 8'h33, 8'h44, 8'h55, 8'h33, 8'h77, 8'hCC);
    step();

    // reset mid-frame discards held bytes
    bus.in_valid = 1'b1; bus.in_data = 8'h61; step();
    drive(8'h62, 1'b0);
    rst_n = 1'b0;
    step();
    chk_zero("mid_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("mid_rst_noframe", 32'(bus.sig_a), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data = 8'h71; step();
    bus.in_data = 8'h72; step();
    drive(8'h73, 1'b0);
    chk_frame("post_rst", 2'd3, 8'h71, 8'h72, 8'h73, 8'h71, 8'hE3, 8'h56);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
